// File: rtl/toggle_period_meter.sv
// toggle_period_meter: measures sig_in half-period (sys_clk, sys_rst, sig_in, clr -> half_period, meas_valid, in_range, timeout, edge_count)
module toggle_period_meter #(
  parameter int CNT_W = 27,
  parameter logic [CNT_W-1:0] EXP_HALF = CNT_W'(25),
  parameter logic [CNT_W-1:0] TOL = CNT_W'(1),
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(100)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             sig_in,
  input  logic             clr,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             in_range,
  output logic             timeout,
  output logic [15:0]      edge_count
);
  typedef enum logic [1:0] {IDLE, MEASURE, STALL} state_t;
  state_t state;
  logic s1, s2, s3, sig_edge;
  logic [1:0] mask_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0] diff, dev;
  always_comb begin
    sig_edge = (s2 ^ s3) & (mask_cnt == 2'd3);
    diff = {1'b0, cnt} - {1'b0, EXP_HALF};
    dev = diff[CNT_W] ? -diff : diff;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      {s1, s2, s3} <= 3'b000;
      mask_cnt <= 2'd0;
      state <= IDLE;
      cnt <= '0;
      half_period <= '0;
      meas_valid <= 1'b0;
      in_range <= 1'b0;
      timeout <= 1'b0;
      edge_count <= 16'd0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
      mask_cnt <= (mask_cnt == 2'd3) ? mask_cnt : mask_cnt + 2'd1;
      meas_valid <= 1'b0;
      if (clr) begin
        state <= IDLE;
        cnt <= '0;
        half_period <= '0;
        in_range <= 1'b0;
        timeout <= 1'b0;
        edge_count <= 16'd0;
      end else begin
        cnt <= sig_edge ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
        case (state)
          IDLE: state <= sig_edge ? MEASURE : IDLE;
          MEASURE:
            if (sig_edge) begin
              half_period <= cnt;
              in_range <= dev <= {1'b0, TOL};
              meas_valid <= 1'b1;
              edge_count <= &edge_count ? edge_count : edge_count + 16'd1;
            end else if (cnt == TIMEOUT) begin
              state <= STALL;
              timeout <= 1'b1;
            end
          STALL:
            if (sig_edge) begin
              state <= MEASURE;
              timeout <= 1'b0;
            end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_toggle_period_meter.sv
// tb_toggle_period_meter: scoreboard bench for toggle_period_meter
module tb_toggle_period_meter;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic sig_in = 1'b0;
  logic clr = 1'b0;
  logic [26:0] half_period;
  logic meas_valid, in_range, timeout;
  logic [15:0] edge_count;
  toggle_period_meter dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .sig_in(sig_in),
    .clr(clr),
    .half_period(half_period),
    .meas_valid(meas_valid),
    .in_range(in_range),
    .timeout(timeout),
    .edge_count(edge_count)
  );
  always #5 sys_clk = ~sys_clk;
  typedef struct {int hp; int ir; int ec; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int m_last = 0;
  int m_ec = 0;
  bit m_idle = 1'b1;
  always @(posedge sys_clk) cyc <= cyc + 1;
  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    check({tag, "_half_period"}, half_period, 0);
    check({tag, "_meas_valid"}, meas_valid, 0);
    check({tag, "_in_range"}, in_range, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_edge_count"}, edge_count, 0);
  endtask
  task automatic tog(input int n);
    int sp, d;
    repeat (n) @(posedge sys_clk);
    #1 sig_in = ~sig_in;
    sp = cyc - m_last;
    m_last = cyc;
    d = sp - 25;
    if (m_idle) m_idle = 1'b0;
    else if (sp <= 100) begin
      m_ec = (m_ec == 65535) ? m_ec : m_ec + 1;
      q.push_back('{sp, int'(d >= -1 && d <= 1), m_ec, cyc + 3});
    end
  endtask
  task automatic drain(input string tag);
    repeat (5) @(posedge sys_clk);
    #1 check({"drain_", tag}, q.size(), 0);
  endtask
  task automatic do_reset(input int n);
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    m_idle = 1'b1;
    m_ec = 0;
    repeat (n) @(posedge sys_clk);
    #1 chk_zero("rst");
    sys_rst = 1'b0;
    repeat (8) @(posedge sys_clk);
  endtask
  always @(negedge sys_clk)
    if (meas_valid === 1'b1) begin
      check("meas_pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("half_period", half_period, e.hp);
        check("in_range", in_range, e.ir);
        check("edge_count", edge_count, e.ec);
        check("meas_cycle", cyc, e.cyc);
      end
    end
  initial begin
    repeat (3) @(posedge sys_clk);
    #1 chk_zero("init");
    sys_rst = 1'b0;
    repeat (5) @(posedge sys_clk);
    repeat (6) tog(25);
    repeat (3) tog(27);
    repeat (3) tog(24);
    repeat (2) tog(26);
    tog(23);
    drain("patterns");
    repeat (2) tog(25);
    repeat (102) @(posedge sys_clk);
    #1 check("timeout_early", timeout, 0);
    @(posedge sys_clk);
    #1 check("timeout_set", timeout, 1);
    check("timeout_hold_half", half_period, 25);
    tog(47);
    repeat (2) @(posedge sys_clk);
    #1 check("timeout_before_edge", timeout, 1);
    @(posedge sys_clk);
    #1 check("timeout_cleared", timeout, 0);
    tog(22);
    tog(25);
    drain("stall");
    tog(100);
    repeat (4) @(posedge sys_clk);
    #1 check("no_stall_at_timeout", timeout, 0);
    tog(25);
    drain("edge_at_timeout");
    tog(25);
    repeat (10) @(posedge sys_clk);
    #1 clr = 1'b1;
    m_idle = 1'b1;
    m_ec = 0;
    @(posedge sys_clk);
    #1 clr = 1'b0;
    chk_zero("clr");
    repeat (4) tog(25);
    drain("clr");
    tog(25);
    if (sig_in == 1'b0) tog(25);
    repeat (10) @(posedge sys_clk);
    do_reset(2);
    repeat (4) tog(25);
    drain("reset");
    do_reset(2);
    repeat (65540) tog(1);
    drain("saturate");
    check("sat_edge_count", edge_count, 16'hFFFF);
    check("sat_half_period", half_period, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
